// File: rtl/decode_stage.sv
// Decode stage: instruction field/immediate decode, register file read with
// write-back bypass, RAW scoreboard interlock and a one-entry output register.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush
);

  localparam int AW = $clog2(NREGS);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  function automatic logic idx_ok(input logic [4:0] idx);
    return int'({27'd0, idx}) < NREGS;
  endfunction

  // Field extraction
  logic [6:0] opcode;
  logic [4:0] rd_idx, rs1_idx, rs2_idx;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode  = in_instr[6:0];
  assign rd_idx  = in_instr[11:7];
  assign f3      = in_instr[14:12];
  assign rs1_idx = in_instr[19:15];
  assign rs2_idx = in_instr[24:20];
  assign f7      = in_instr[31:25];

  logic is_r, is_i, is_ld, is_s, is_b, is_jal, is_jalr, is_lui, is_auipc;
  logic known, uses_rs1, uses_rs2, writes, illegal;
  logic use1, use2, sets_rd;
  logic [31:0] imm32;

  always_comb begin
    is_r     = (opcode == OP_R);
    is_i     = (opcode == OP_IALU);
    is_ld    = (opcode == OP_LOAD);
    is_s     = (opcode == OP_STORE);
    is_b     = (opcode == OP_BR);
    is_jal   = (opcode == OP_JAL);
    is_jalr  = (opcode == OP_JALR);
    is_lui   = (opcode == OP_LUI);
    is_auipc = (opcode == OP_AUIPC);
    known    = is_r | is_i | is_ld | is_s | is_b | is_jal | is_jalr | is_lui | is_auipc;
    uses_rs1 = is_r | is_s | is_b | is_i | is_ld | is_jalr;
    uses_rs2 = is_r | is_s | is_b;
    writes   = is_r | is_i | is_ld | is_jal | is_jalr | is_lui | is_auipc;
    // Out-of-range indices only matter for fields the format actually uses
    illegal  = !known
             | (uses_rs1 & !idx_ok(rs1_idx))
             | (uses_rs2 & !idx_ok(rs2_idx))
             | (writes   & !idx_ok(rd_idx));
    use1     = !illegal & uses_rs1 & (rs1_idx != 5'd0);
    use2     = !illegal & uses_rs2 & (rs2_idx != 5'd0);
    sets_rd  = !illegal & writes & (rd_idx != 5'd0);
  end

  always_comb begin
    imm32 = 32'd0;
    if (is_i || is_ld || is_jalr)
      imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
    else if (is_s)
      imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    else if (is_b)
      imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    else if (is_lui || is_auipc)
      imm32 = {in_instr[31:12], 12'd0};
    else if (is_jal)
      imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  end

  logic [XLEN-1:0] imm_ext;
  generate
    if (XLEN == 32) begin : g_imm32
      assign imm_ext = imm32;
    end else begin : g_immx
      assign imm_ext = {{(XLEN-32){imm32[31]}}, imm32};
    end
  endgenerate

  // Register file, cleared by reset; x0 is never written
  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en && wb_addr != 5'd0 && idx_ok(wb_addr)) begin
      regs[wb_addr[AW-1:0]] <= wb_data;
    end
  end

  logic byp1, byp2;
  logic [XLEN-1:0] rs1_val, rs2_val;

  always_comb begin
    byp1    = wb_en && (wb_addr == rs1_idx);
    byp2    = wb_en && (wb_addr == rs2_idx);
    rs1_val = '0;
    rs2_val = '0;
    if (use1) rs1_val = byp1 ? wb_data : regs[rs1_idx[AW-1:0]];
    if (use2) rs2_val = byp2 ? wb_data : regs[rs2_idx[AW-1:0]];
  end

  // Scoreboard and interlock
  logic [31:0] pending_reg, pending_next;
  logic [31:0] set_vec, wb_clr, flush_clr;
  logic        hazard, accept;

  logic            out_valid_reg, out_illegal_reg, held_sets_reg;
  logic [6:0]      out_opcode_reg, out_funct7_reg;
  logic [2:0]      out_funct3_reg;
  logic [4:0]      out_rd_reg;
  logic [XLEN-1:0] out_rs1_reg, out_rs2_reg, out_imm_reg, out_pc_reg;

  assign hazard = in_valid & ((use1 & pending_reg[rs1_idx] & !byp1)
                            | (use2 & pending_reg[rs2_idx] & !byp2));
  assign in_ready = !reset & !flush & !hazard & (!out_valid_reg | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    set_vec   = (accept && sets_rd) ? (32'd1 << rd_idx) : 32'd0;
    wb_clr    = wb_en ? (32'd1 << wb_addr) : 32'd0;
    // Only the bit the discarded bundle itself set is withdrawn
    flush_clr = (flush && out_valid_reg && held_sets_reg) ? (32'd1 << out_rd_reg) : 32'd0;
    pending_next = (pending_reg & ~wb_clr & ~flush_clr) | set_vec;
  end

  always_ff @(posedge clk) begin
    if (reset) pending_reg <= '0;
    else       pending_reg <= pending_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg   <= 1'b0;
      out_illegal_reg <= 1'b0;
      held_sets_reg   <= 1'b0;
      out_opcode_reg  <= '0;
      out_funct3_reg  <= '0;
      out_funct7_reg  <= '0;
      out_rd_reg      <= '0;
      out_rs1_reg     <= '0;
      out_rs2_reg     <= '0;
      out_imm_reg     <= '0;
      out_pc_reg      <= '0;
    end else if (accept) begin
      out_valid_reg   <= 1'b1;
      out_illegal_reg <= illegal;
      held_sets_reg   <= sets_rd;
      out_opcode_reg  <= opcode;
      out_funct3_reg  <= (is_lui || is_auipc || is_jal) ? 3'd0 : f3;
      out_funct7_reg  <= is_r ? f7 : 7'd0;
      out_rd_reg      <= (is_s || is_b) ? 5'd0 : rd_idx;
      out_rs1_reg     <= rs1_val;
      out_rs2_reg     <= rs2_val;
      out_imm_reg     <= is_r ? '0 : imm_ext;
      out_pc_reg      <= in_pc;
    end else if (flush || out_ready) begin
      out_valid_reg   <= 1'b0;
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_illegal  = out_illegal_reg;
  assign out_opcode   = out_opcode_reg;
  assign out_funct3   = out_funct3_reg;
  assign out_funct7   = out_funct7_reg;
  assign out_rd       = out_rd_reg;
  assign out_rs1_data = out_rs1_reg;
  assign out_rs2_data = out_rs2_reg;
  assign out_imm      = out_imm_reg;
  assign out_pc       = out_pc_reg;

endmodule
